// File: rtl/wb_i2c_if_if.sv
// wb_i2c_if_if: Wishbone classic register-port bundle for the I2C master.
// Signals: cyc_i/stb_i/we_i/adr_i[1:0]/dat_i[7:0] from the bus master;
// ack_o/dat_o[7:0]/irq back from the I2C controller.
// Modports: master (bus side), slave (controller side).
interface wb_i2c_if_if;
  logic       cyc_i, stb_i, we_i, ack_o, irq;
  logic [1:0] adr_i;
  logic [7:0] dat_i, dat_o;
  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input ack_o, dat_o, irq);
  modport slave (input cyc_i, stb_i, we_i, adr_i, dat_i, output ack_o, dat_o, irq);
endinterface

// File: rtl/wb_i2c_if.sv
// wb_i2c_if: Wishbone-controlled byte-level I2C master.
// Ports: clk_i, rst_i (sync, active high); wb (wb_i2c_if_if.slave: cyc/stb/we/adr/dat_i,
// ack/dat_o, irq); scl_i/sda_i sampled lines; scl_o/sda_o open-drain drives (1 = release).
// Registers: 0 CSR {E,IE,BB,BC,0000}, 1 DPR (tx on write, rx on read),
// 2 CMDR {DON,NAK,AL,ERR,0,CMD}, 3 FSMR {0000,state}.
// Macro WB_I2C_IF_IRQ_EN: enables irq and CSR.IE; when undefined irq is 0 and IE reads 0.
module wb_i2c_if #(parameter int CLK_DIV = 250) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_i2c_if_if.slave wb,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);
`ifdef WB_I2C_IF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int CW = $clog2(CLK_DIV + 1);
  typedef enum logic [3:0] {IDLE, START, WRITE_BIT, ACK_IN, READ_BIT, ACK_OUT, STOP, DONE} state_t;
  state_t        st_q, ns_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    ph_q;
  logic [2:0]    bit_q, cmd;
  logic [7:0]    tx_q, rx_q, sh_q, dat_q, rd_d;
  logic          e_q, ie_q, bb_q, bc_q, don_q, nak_q, al_q, err_q, nakp_q, rnak_q, irq_q, ack_q, scl_q, sda_q;
  logic          req, wr, rd, scl_d, sda_d, hold, tick, bit_st, al_c, cmd_err;
  assign req = wb.cyc_i & wb.stb_i & ~ack_q;
  assign wr = req & wb.we_i;
  assign rd = req & ~wb.we_i;
  assign cmd = wb.dat_i[2:0];
  assign cmd_err = cmd == 3'b000 || cmd == 3'b111 || (cmd == 3'b110 && tx_q != 8'd0) ||
                   (!bc_q && (cmd == 3'b001 || cmd[2:1] == 2'b01));
  assign bit_st = st_q inside {WRITE_BIT, ACK_IN, READ_BIT, ACK_OUT};
  // a released SCL that still reads low is being stretched by a slave
  assign hold = scl_d & ~scl_i;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  assign al_c = (st_q == START || st_q == WRITE_BIT) && sda_q && scl_q && scl_i && !sda_i;
  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;
  assign wb.irq = IRQ_EN & irq_q;
  assign scl_o = scl_q;
  assign sda_o = sda_q;
  always_comb begin
    ns_d = cmd == 3'b100 ? START : cmd == 3'b001 ? WRITE_BIT : cmd == 3'b101 ? STOP :
           cmd == 3'b110 ? DONE : READ_BIT;
    rd_d = wb.adr_i == 2'd0 ? {e_q, ie_q, bb_q, bc_q, 4'd0} :
           wb.adr_i == 2'd1 ? rx_q :
           wb.adr_i == 2'd2 ? {don_q, nak_q, al_q, err_q, 4'd0} : {4'd0, st_q};
    // between commands the owner of the bus parks SCL low; otherwise both lines float
    scl_d = ~bc_q;
    sda_d = bc_q ? sda_q : 1'b1;
    if (st_q == START) begin
      scl_d = ph_q == 2'd0 ? scl_q : ph_q != 2'd3;
      sda_d = ph_q < 2'd2;
    end else if (st_q == STOP) begin
      scl_d = ph_q[1];
      sda_d = ph_q == 2'd0 ? sda_q : ph_q == 2'd3;
    end else if (bit_st) begin
      // SDA moves in quarter 1 so it never changes alongside an SCL edge
      scl_d = ph_q[1];
      sda_d = ph_q == 2'd0 ? sda_q : st_q == WRITE_BIT ? sh_q[7] : st_q == ACK_OUT ? rnak_q : 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      {cnt_q, ph_q, bit_q} <= '0;
      {tx_q, rx_q, sh_q, dat_q} <= '0;
      {e_q, ie_q, bb_q, bc_q, nak_q, al_q, err_q, nakp_q, rnak_q, irq_q, ack_q} <= '0;
      {don_q, scl_q, sda_q} <= 3'b111;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      if (rd && wb.adr_i == 2'd2) irq_q <= 1'b0;
      if (wr && wb.adr_i == 2'd0) begin
        e_q <= wb.dat_i[7];
        ie_q <= IRQ_EN & wb.dat_i[6];
      end
      if (wr && wb.adr_i == 2'd1) tx_q <= wb.dat_i;
      if (!e_q) begin
        st_q <= IDLE;
        bb_q <= 1'b0;
        bc_q <= 1'b0;
      end else if (st_q == IDLE) begin
        if (wr && wb.adr_i == 2'd2) begin
          {don_q, nak_q, al_q} <= 3'b0;
          err_q <= cmd_err;
          if (cmd_err && ie_q) irq_q <= 1'b1;
          st_q <= cmd_err ? IDLE : ns_d;
          rnak_q <= cmd[0];
          {cnt_q, ph_q, bit_q, nakp_q} <= '0;
          sh_q <= tx_q;
        end
      end else if (st_q == DONE) begin
        don_q <= 1'b1;
        nak_q <= nakp_q;
        if (ie_q) irq_q <= 1'b1;
        st_q <= IDLE;
      end else if (al_c) begin
        al_q <= 1'b1;
        bc_q <= 1'b0;
        if (ie_q) irq_q <= 1'b1;
        st_q <= IDLE;
      end else if (!hold) begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick) ph_q <= ph_q + 2'd1;
        // sample at the midpoint of the SCL high time
        if (tick && ph_q == 2'd2 && st_q == READ_BIT) sh_q <= {sh_q[6:0], sda_i};
        if (tick && ph_q == 2'd2 && st_q == ACK_IN) nakp_q <= sda_i;
        if (tick && ph_q == 2'd3) begin
          bit_q <= bit_q + 3'd1;
          case (st_q)
            START: begin
              bb_q <= 1'b1;
              bc_q <= 1'b1;
              st_q <= DONE;
            end
            STOP: begin
              bb_q <= 1'b0;
              bc_q <= 1'b0;
              st_q <= DONE;
            end
            WRITE_BIT: begin
              sh_q <= {sh_q[6:0], 1'b0};
              st_q <= &bit_q ? ACK_IN : WRITE_BIT;
            end
            READ_BIT: begin
              if (&bit_q) rx_q <= sh_q;
              st_q <= &bit_q ? ACK_OUT : READ_BIT;
            end
            default: st_q <= DONE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_i2c_if.sv
// tb_wb_i2c_if: directed self-checking bench for wb_i2c_if with a scripted I2C slave.
module tb_wb_i2c_if;
`ifdef WB_I2C_IF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [7:0] IE = IRQ_EN ? 8'h40 : 8'h00;
  logic clk = 1'b0, rst = 1'b1;
  logic scl_o, sda_o, scl_i, sda_i;
  logic slv_sda = 1'b1, ext_sda = 1'b1;
  int checks = 0, errors = 0, scl_falls = 0;
  wb_i2c_if_if bus();
  assign scl_i = scl_o;
  assign sda_i = sda_o & slv_sda & ext_sda;
  wb_i2c_if #(.CLK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
  );
  always #5 clk = ~clk;
  always @(negedge scl_o) scl_falls++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wd, output logic [7:0] rdat);
    int n = 0;
    @(negedge clk);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i = we;
    bus.adr_i = adr;
    bus.dat_i = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < 20);
    check("ack_lat", n, 1);
    rdat = bus.dat_o;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i = 1'b0;
    @(negedge clk);
    check("ack_low", bus.ack_o, 1'b0);
  endtask
  task automatic wb_wr(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] x;
    wb_xfer(1'b1, adr, d, x);
  endtask
  task automatic wb_rd(input logic [1:0] adr, output logic [7:0] d);
    wb_xfer(1'b0, adr, 8'h00, d);
  endtask
  task automatic wait_scl(input logic lvl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scl_o !== lvl && n < 400);
    if (scl_o !== lvl) check("scl_tmo", scl_o, lvl);
  endtask
  task automatic wait_idle;
    logic [7:0] v;
    int n = 0;
    do begin
      wb_rd(2'd3, v);
      n++;
    end while (v != 8'h00 && n < 300);
    check("idle", v, 8'h00);
  endtask
  task automatic write_byte(input logic [7:0] b, input logic ack, output logic [7:0] seen);
    wb_wr(2'd1, b);
    wb_wr(2'd2, 8'h01);
    seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_scl(1'b1);
      seen = {seen[6:0], sda_i};
      wait_scl(1'b0);
    end
    slv_sda = ~ack;
    wait_scl(1'b1);
    wait_scl(1'b0);
    slv_sda = 1'b1;
    wait_idle;
  endtask
  task automatic read_byte(input logic [7:0] b, input logic nak, output logic a9);
    slv_sda = b[7];
    wb_wr(2'd2, nak ? 8'h03 : 8'h02);
    for (int i = 7; i >= 0; i--) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
      slv_sda = i > 0 ? b[i-1] : 1'b1;
    end
    wait_scl(1'b1);
    a9 = sda_i;
    wait_scl(1'b0);
    wait_idle;
  endtask
  initial begin
    logic [7:0] v, s;
    logic a;
    int f;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i = 1'b0;
    bus.adr_i = 2'd0;
    bus.dat_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", scl_o, 1'b1);
    check("rst_sda", sda_o, 1'b1);
    check("rst_ack", bus.ack_o, 1'b0);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_dat", bus.dat_o, 8'h00);
    rst = 1'b0;
    wb_rd(2'd0, v); check("rst_csr", v, 8'h00);
    wb_rd(2'd2, v); check("rst_cmdr", v, 8'h80);
    wb_rd(2'd3, v); check("rst_fsmr", v, 8'h00);
    wb_rd(2'd1, v); check("rst_dpr", v, 8'h00);
    wb_wr(2'd0, 8'hC0);
    wb_rd(2'd0, v); check("csr_en", v, 8'h80 | IE);
    wb_wr(2'd2, 8'h06); wait_idle;
    wb_rd(2'd2, v); check("setbus", v, 8'h80);
    wb_wr(2'd2, 8'h04); wait_idle;
    check("start_irq", bus.irq, IRQ_EN);
    wb_rd(2'd2, v); check("start_cmdr", v, 8'h80);
    check("irq_clr", bus.irq, 1'b0);
    wb_rd(2'd0, v); check("start_csr", v, 8'hB0 | IE);
    write_byte(8'h44, 1'b1, s);
    check("wr44_bits", s, 8'h44);
    check("wr44_irq", bus.irq, IRQ_EN);
    wb_rd(2'd2, v); check("wr44_cmdr", v, 8'h80);
    wb_rd(2'd0, v); check("wr44_bb", v[5], 1'b1);
    write_byte(8'hAA, 1'b0, s);
    check("wrAA_bits", s, 8'hAA);
    wb_rd(2'd2, v); check("wrAA_nak", v, 8'hC0);
    wb_wr(2'd2, 8'h04); wait_idle;
    wb_rd(2'd2, v); check("rstart", v, 8'h80);
    write_byte(8'h45, 1'b1, s);
    check("wr45_bits", s, 8'h45);
    wb_rd(2'd2, v); check("wr45_cmdr", v, 8'h80);
    read_byte(8'd100, 1'b0, a);
    check("rdack_9th", a, 1'b0);
    wb_rd(2'd2, v); check("rdack_cmdr", v, 8'h80);
    wb_rd(2'd1, v); check("rdack_dpr", v, 8'd100);
    read_byte(8'd101, 1'b1, a);
    check("rdnak_9th", a, 1'b1);
    wb_rd(2'd1, v); check("rdnak_dpr", v, 8'd101);
    wb_wr(2'd2, 8'h05); wait_idle;
    wb_rd(2'd2, v); check("stop_cmdr", v, 8'h80);
    wb_rd(2'd0, v); check("stop_csr", v, 8'h80 | IE);
    check("stop_scl", scl_o, 1'b1);
    check("stop_sda", sda_o, 1'b1);
    f = scl_falls;
    wb_wr(2'd2, 8'h01);
    repeat (40) @(negedge clk);
    check("err_noscl", scl_falls - f, 0);
    wb_rd(2'd2, v); check("err_nobc", v, 8'h10);
    wb_wr(2'd2, 8'h07);
    wb_rd(2'd2, v); check("err_111", v, 8'h10);
    wb_wr(2'd1, 8'h05);
    wb_wr(2'd2, 8'h06);
    wb_rd(2'd2, v); check("err_setbus", v, 8'h10);
    wb_wr(2'd2, 8'h04); wait_idle;
    wb_wr(2'd1, 8'h80);
    wb_wr(2'd2, 8'h01);
    ext_sda = 1'b0;
    wait_idle;
    wb_rd(2'd2, v); check("al_cmdr", v, 8'h20);
    wb_rd(2'd0, v); check("al_bc", v[4], 1'b0);
    check("al_scl", scl_o, 1'b1);
    check("al_sda", sda_o, 1'b1);
    ext_sda = 1'b1;
    wb_wr(2'd2, 8'h04); wait_idle;
    wb_wr(2'd1, 8'hFF);
    wb_wr(2'd2, 8'h01);
    wait_scl(1'b1);
    wb_wr(2'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("dis_scl", scl_o, 1'b1);
    check("dis_sda", sda_o, 1'b1);
    wb_rd(2'd3, v); check("dis_fsmr", v, 8'h00);
    wb_rd(2'd0, v); check("dis_csr", v, 8'h00);
    wb_wr(2'd0, 8'hC0);
    wb_wr(2'd2, 8'h04); wait_idle;
    wb_wr(2'd2, 8'h01);
    wait_scl(1'b1);
    wait_scl(1'b0);
    check("pre_rst_scl", scl_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_scl", scl_o, 1'b1);
    check("mrst_sda", sda_o, 1'b1);
    rst = 1'b0;
    wb_rd(2'd2, v); check("mrst_cmdr", v, 8'h80);
    wb_rd(2'd0, v); check("mrst_csr", v, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_i2c_if.md
WB_I2C_IF -- requirements
Module: wb_i2c_if

Interface
REQ-001 Parameter CLK_DIV, default 250, system clocks per SCL quarter-period (100 kHz SCL at 100 MHz).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- ack_o  out  1  Wishbone acknowledge
- adr_i  in  2  register address
- we_i  in  1  write enable
- dat_i  in  8  write data
- dat_o  out  8  read data
- irq  out  1  level interrupt
- scl_i  in  1  sampled SCL
- sda_i  in  1  sampled SDA
- scl_o  out  1  0 = pull SCL low, 1 = release
- sda_o  out  1  0 = pull SDA low, 1 = release

Function
REQ-004 Register map:
- 0 CSR: bit7 E (enable, RW); bit6 IE (RW); bit5 BB (bus busy, RO); bit4 BC (bus captured, RO); bits3:0 read 0.
- 1 DPR: write loads tx byte; read returns last received byte.
- 2 CMDR: bits2:0 CMD (write); bit7 DON, bit6 NAK, bit5 AL, bit4 ERR (RO status).
- 3 FSMR: bits3:0 byte-FSM state code (RO); bits7:4 read 0.
REQ-005 Wishbone classic: ack_o goes high the cycle after cyc_i&stb_i, stays high exactly one cycle, then low for at least one cycle; register write or read capture happens on the ack cycle.
REQ-006 dat_o holds the addressed register on the ack cycle; value is don't-care otherwise but is held stable.
REQ-007 Command codes:
- 100 Start
- 001 Write DPR byte
- 010 Read with ACK
- 011 Read with NAK
- 101 Stop
- 110 Set Bus (DPR must be 0, else ERR)
- 000 and 111 are illegal and set ERR.
REQ-008 A CMDR write clears DON/NAK/AL/ERR and starts the command; writes while a command executes, or while E=0, are ignored.
REQ-009 Byte FSM states: IDLE, START, WRITE_BIT(x8), ACK_IN, READ_BIT(x8), ACK_OUT, STOP, DONE; each bit uses 4 quarter-periods of CLK_DIV cycles (SDA changes only while SCL low).
REQ-010 Start: SDA falls while SCL high, then SCL falls; BB=1, BC=1. Repeated Start is allowed while BC=1.
REQ-011 Write: MSB first; the 9th-clock SDA sample is ACK; a sampled 1 sets NAK together with DON.
REQ-012 Read: sample sda_i on the SCL high midpoint, MSB first, store to DPR; the 9th bit drives 0 for Read-ACK and 1 for Read-NAK.
REQ-013 Stop: SDA rises while SCL high; BB=0, BC=0.
REQ-014 Arbitration: if sda_o=1 while SCL is high and sda_i=0 during Write or Start, set AL, release both lines, clear BC, and return to IDLE.
REQ-015 Write or Read issued while BC=0 sets ERR without bus activity.
REQ-016 Completion sets exactly one of DON, DON+NAK, AL or ERR; irq rises the same cycle if IE=1.
REQ-017 A CMDR read on the ack cycle clears irq.
REQ-018 Clearing E aborts any command, releases scl_o/sda_o, and clears BB/BC.
REQ-019 Clock stretching: the high quarter does not start counting until scl_i reads 1.

Reset
REQ-020 On rst_i: ack_o=0, dat_o=0, irq=0, scl_o=1, sda_o=1, CSR=0x00, DPR=0x00, CMDR=0x80 (DON), FSM=IDLE.
REQ-021 Reset mid-transfer releases the bus the next cycle with no Stop generated.

Configuration
REQ-022 Macro WB_I2C_IF_IRQ_EN: when defined, irq behaves per REQ-016/017; when undefined, irq is tied 0 and CSR.IE reads 0 and ignores writes.

Verification
REQ-023 Reset then read CSR and CMDR -> 0x00 and 0x80; scl_o=sda_o=1.
REQ-024 CSR=0xC0; Set Bus with DPR=0; Start; DPR=0x44; Write; slave ACKs -> DON=1, irq=1, SDA bit sequence 0100_0100, BB=1.
REQ-025 Write 0xAA while the slave leaves SDA high on the 9th clock -> CMDR=0xC0 (DON+NAK).
REQ-026 Start, address 0x45, Read-ACK with slave bytes 100 then 101 via Read-NAK, Stop -> DPR reads 100 then 101; 9th bits 0 then 1; BB=0.
REQ-027 Write with BC=0 -> ERR=1, no SCL toggling; write CMD=111 -> ERR=1.
REQ-028 External SDA forced low while master sends a 1 -> AL=1, lines released, BC=0.
